iterative_divider: RTL and testbench

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

---
 rtl/iterative_divider_pkg.sv | 22 ++
 rtl/iterative_divider_div_step.sv | 29 ++
 rtl/iterative_divider.sv | 199 +++++++++++++++++++
 tb/tb_iterative_divider.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared encodings for the iterative divider: RV32M op codes and FSM states.
package iterative_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // DIV and REM treat operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// One combinational step of an unsigned restoring divide (shift, compare, subtract).
module div_step #(
  parameter int n = 32
) (
  input  logic [n-1:0] rem_in,
  input  logic [n-1:0] quo_in,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] rem_out,
  output logic [n-1:0] quo_out
);

  logic [n:0] shifted_s;
  logic [n:0] diff_s;
  logic       ge_s;

  // Partial remainder is always below the divisor, so the difference fits in n bits.
  always_comb begin
    shifted_s = {rem_in, quo_in[n-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    ge_s      = (shifted_s >= {1'b0, divisor});
    if (ge_s) begin
      rem_out = diff_s[n-1:0];
    end else begin
      rem_out = shifted_s[n-1:0];
    end
    quo_out = {quo_in[n-2:0], ge_s};
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M divider: one restoring step per cycle, fast path for /0 and overflow.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [1:0]   op,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  input  logic [4:0]   rdAdd,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] writeData,
  output logic [4:0]   writeAdd,
  output logic         regWrite
);

  localparam int           CW       = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [n-1:0]  ALL_ONES = {n{1'b1}};
  localparam logic [n-1:0]  ZERO     = {n{1'b0}};
  localparam logic [n-1:0]  MIN_NEG  = {1'b1, {(n-1){1'b0}}};

  state_e        state_r, state_s;
  logic [n-1:0]  rem_r, rem_s;
  logic [n-1:0]  quo_r, quo_s;
  logic [n-1:0]  dvsr_r, dvsr_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          neg_q_r, neg_q_s;
  logic          neg_r_r, neg_r_s;
  logic          rem_sel_r, rem_sel_s;
  logic [4:0]    rd_r, rd_s;
  logic [n-1:0]  wdata_r, wdata_s;
  logic [4:0]    wadd_r, wadd_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          regw_r, regw_s;

  logic [n-1:0]  rem_step_s, quo_step_s;
  logic [n-1:0]  q_fix_s, r_fix_s, result_s;
  logic [n-1:0]  dvd_mag_s, dvs_mag_s;
  logic          signed_s, div_zero_s, ovf_s;

  div_step #(.n(n)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (dvsr_r),
    .rem_out (rem_step_s),
    .quo_out (quo_step_s)
  );

  // Operand classification and sign fix-up of the final iteration's output.
  always_comb begin
    signed_s   = op_is_signed(op);
    div_zero_s = (divisor == ZERO);
    ovf_s      = signed_s && (dividend == MIN_NEG) && (divisor == ALL_ONES);
    if (signed_s && dividend[n-1]) begin
      dvd_mag_s = -dividend;
    end else begin
      dvd_mag_s = dividend;
    end
    if (signed_s && divisor[n-1]) begin
      dvs_mag_s = -divisor;
    end else begin
      dvs_mag_s = divisor;
    end
    if (neg_q_r) begin
      q_fix_s = -quo_step_s;
    end else begin
      q_fix_s = quo_step_s;
    end
    if (neg_r_r) begin
      r_fix_s = -rem_step_s;
    end else begin
      r_fix_s = rem_step_s;
    end
    if (rem_sel_r) begin
      result_s = r_fix_s;
    end else begin
      result_s = q_fix_s;
    end
  end

  // Next-state and next-datapath values; everything holds unless a transition says otherwise.
  always_comb begin
    state_s   = state_r;
    rem_s     = rem_r;
    quo_s     = quo_r;
    dvsr_s    = dvsr_r;
    cnt_s     = cnt_r;
    neg_q_s   = neg_q_r;
    neg_r_s   = neg_r_r;
    rem_sel_s = rem_sel_r;
    rd_s      = rd_r;
    wdata_s   = wdata_r;
    wadd_s    = wadd_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (start) begin
          rem_sel_s = op[1];
          rd_s      = rdAdd;
          neg_q_s   = (op == OP_DIV) && (dividend[n-1] != divisor[n-1]);
          neg_r_s   = (op == OP_REM) && dividend[n-1];
          if (div_zero_s) begin
            wdata_s = op[1] ? dividend : ALL_ONES;
            wadd_s  = rdAdd;
            state_s = ST_DONE;
          end else if (ovf_s) begin
            wdata_s = op[1] ? ZERO : dividend;
            wadd_s  = rdAdd;
            state_s = ST_DONE;
          end else begin
            rem_s   = ZERO;
            quo_s   = dvd_mag_s;
            dvsr_s  = dvs_mag_s;
            cnt_s   = {CW{1'b0}};
            state_s = ST_BUSY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else begin
          rem_s = rem_step_s;
          quo_s = quo_step_s;
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            wdata_s = result_s;
            wadd_s  = rd_r;
            state_s = ST_DONE;
          end else begin
            state_s = ST_BUSY;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
    regw_s = done_s && (wadd_s != 5'd0);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      rem_r     <= ZERO;
      quo_r     <= ZERO;
      dvsr_r    <= ZERO;
      cnt_r     <= {CW{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      rem_sel_r <= 1'b0;
      rd_r      <= 5'd0;
      wdata_r   <= ZERO;
      wadd_r    <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      regw_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      rem_r     <= rem_s;
      quo_r     <= quo_s;
      dvsr_r    <= dvsr_s;
      cnt_r     <= cnt_s;
      neg_q_r   <= neg_q_s;
      neg_r_r   <= neg_r_s;
      rem_sel_r <= rem_sel_s;
      rd_r      <= rd_s;
      wdata_r   <= wdata_s;
      wadd_r    <= wadd_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      regw_r    <= regw_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign regWrite  = regw_r;
  assign writeData = wdata_r;
  assign writeAdd  = wadd_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: expected writes are queued at issue and checked on done.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = 32'h0;
  logic [31:0] divisor = 32'h0;
  logic [4:0]  rd_add = 5'd0;
  logic        busy, done, reg_write;
  logic [31:0] write_data;
  logic [4:0]  write_add;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  add;
    logic        rw;
    int          at;
  } exp_t;
  exp_t sb[$];

  iterative_divider #(.n(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .dividend(dividend), .divisor(divisor), .rdAdd(rd_add),
    .busy(busy), .done(done), .writeData(write_data),
    .writeAdd(write_add), .regWrite(reg_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return o[1] ? a : 32'hFFFFFFFF;
    if (o[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? 32'h0 : a;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Scoreboard monitor: every done must match the oldest expected write, in the exact cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: cycle=%0d data=%h add=%0d", cyc, write_data, write_add);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (write_data !== e.data || write_add !== e.add || reg_write !== e.rw || cyc !== e.at) begin
            errors++;
            $display("FAIL result: got data=%h add=%0d rw=%b cycle=%0d, want data=%h add=%0d rw=%b cycle=%0d",
                     write_data, write_add, reg_write, cyc, e.data, e.add, e.rw, e.at);
          end
        end
      end else if (reg_write !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL regwrite_outside_done: cycle=%0d regWrite=%b, want 0", cyc, reg_write);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; the current cycle is cycle 0 of the operation.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic push, input logic [31:0] exp_data, input int lat);
    exp_t e;
    op = o; dividend = a; divisor = b; rd_add = rd; start = 1'b1;
    if (push) begin
      e.data = exp_data; e.add = rd; e.rw = (rd != 5'd0); e.at = cyc + lat;
      sb.push_back(e);
    end
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    int n_wait;
    n_wait = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n_wait < 100) begin
      step();
      n_wait++;
    end
    checks++;
    if (n_wait >= 100) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d busy=%b, want 0 pending and busy=0", sb.size(), busy);
      sb.delete();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++;
    if ({busy, done, reg_write} !== 3'b000 || write_data !== 32'h0 || write_add !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b rw=%b data=%h add=%0d, want all 0",
               busy, done, reg_write, write_data, write_add);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    issue(2'b00, 32'd7, 32'hFFFFFFFE, 5'd5, 1'b1, 32'hFFFFFFFD, 33);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_busy: busy=%b, want 1", busy);
    end
    drain();
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 5'd3, 1'b1, 32'hFFFFFFFF, 33);
    drain();
    issue(2'b11, 32'hFFFFFFFF, 32'd16, 5'd12, 1'b1, 32'h0000000F, 33);
    drain();
    issue(2'b01, 32'd100, 32'd7, 5'd31, 1'b1, 32'd14, 33);
    drain();
  endtask

  task automatic test_div_zero();
    issue(2'b01, 32'd42, 32'd0, 5'd1, 1'b1, 32'hFFFFFFFF, 1);
    drain();
    issue(2'b10, 32'd13, 32'd0, 5'd2, 1'b1, 32'd13, 1);
    drain();
  endtask

  task automatic test_overflow();
    issue(2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b1, 32'h80000000, 1);
    drain();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b1, 32'h0, 1);
    drain();
  endtask

  task automatic test_ignore_start();
    issue(2'b00, 32'd1000, 32'd10, 5'd7, 1'b1, 32'd100, 33);
    repeat (4) step();
    issue(2'b01, 32'd9, 32'd3, 5'd20, 1'b0, 32'h0, 0);
    drain();
    issue(2'b01, 32'd9, 32'd3, 5'd0, 1'b1, 32'd3, 33);
    drain();
  endtask

  task automatic test_flush();
    issue(2'b01, 32'd50, 32'd5, 5'd9, 1'b0, 32'h0, 0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({busy, done, reg_write} !== 3'b000) begin
      errors++;
      $display("FAIL flush_busy: busy=%b done=%b rw=%b, want 000", busy, done, reg_write);
    end
    repeat (40) step();
    flush = 1'b1;
    issue(2'b01, 32'd50, 32'd5, 5'd9, 1'b0, 32'h0, 0);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_start: busy=%b, want 0", busy);
    end
    issue(2'b01, 32'd5, 32'd0, 5'd8, 1'b1, 32'hFFFFFFFF, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain();
    issue(2'b01, 32'd50, 32'd5, 5'd9, 1'b1, 32'd10, 33);
    drain();
  endtask

  task automatic test_reset_abort();
    issue(2'b01, 32'd77, 32'd7, 5'd4, 1'b0, 32'h0, 0);
    repeat (9) step();
    rst = 1'b0;
    flush = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b1; flush = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, reg_write} !== 3'b000 || write_data !== 32'h0 || write_add !== 5'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b rw=%b data=%h add=%0d, want all 0",
               busy, done, reg_write, write_data, write_add);
    end
    repeat (40) step();
    issue(2'b01, 32'd77, 32'd7, 5'd4, 1'b1, 32'd11, 33);
    drain();
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      a = (i % 7 == 0) ? 32'h80000000 : $urandom;
      case (i % 5)
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      lat = (b == 32'h0 || (o[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
      issue(o, a, b, 5'($urandom_range(0, 31)), 1'b1, model(o, a, b), lat);
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_flush();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
